// File: rtl/hs_fifo_pkg.sv
// hs_fifo_pkg
// Shared helper for the handshake FIFO: an elaboration-time power-of-two
// test used to validate the DEPTH parameter. No ports.
package hs_fifo_pkg;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// hs_fifo_mem
// WIDTH x DEPTH storage array for hs_fifo: one synchronous write port and one
// asynchronous read port. No reset; contents persist across reset and flush.
//
// Ports:
//   clk_core  clock for the write port
//   wr_en     write strobe
//   wr_addr   write index
//   wr_data   write payload
//   rd_addr   read index
//   rd_data   read payload (combinational from rd_addr)
module hs_fifo_mem #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk_core,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_core) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hs_fifo.sv
// hs_fifo
// Valid/ready first-word-fall-through FIFO. Occupancy is tracked with two
// wrap-bit pointers; all status outputs are derived from registered pointers
// only, so nothing combinationally follows valid_i or ready_i.
//
// Ports:
//   clk_core   sole clock
//   rst_core   synchronous active-high reset (clears pointers)
//   flush_req  discard all held entries (drops any push that cycle)
//   in         upstream payload
//   valid_i    upstream payload valid
//   ready_o    FIFO can accept (~full)
//   out        head-entry payload, valid while valid_o=1
//   valid_o    head entry present (~empty)
//   ready_i    downstream accepts head
//   full       level == DEPTH
//   empty      level == 0
//   level      occupied entries, 0..DEPTH
module hs_fifo
    import hs_fifo_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk_core,
    input  logic                       rst_core,
    input  logic                       flush_req,
    input  logic [WIDTH-1:0]           in,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [WIDTH-1:0]           out,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("hs_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          mem_we;

    assign empty   = (wr_ptr == rd_ptr);
    // Same slot index but different lap means the writer is a full lap ahead.
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level   = wr_ptr - rd_ptr;
    assign ready_o = ~full;
    assign valid_o = ~empty;

    assign push   = valid_i & ready_o;
    assign pop    = valid_o & ready_i;
    assign mem_we = push & ~flush_req & ~rst_core;

    // Pointers span 2*DEPTH and wrap by plain overflow.
    always_ff @(posedge clk_core) begin
        if (rst_core || flush_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    hs_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_core (clk_core),
        .wr_en    (mem_we),
        .wr_addr  (wr_ptr[AW-1:0]),
        .wr_data  (in),
        .rd_addr  (rd_ptr[AW-1:0]),
        .rd_data  (out)
    );

endmodule
